// File: rtl/kbd_ctrl_if.sv
// Handshake and status bundle between the PS/2 keyboard FIFO, kbd_ctrl and the display logic.
// master: keyboard/display side; slave: kbd_ctrl.
interface kbd_ctrl_if;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_valid;
    logic [3:0] cnt_lo;
    logic [3:0] cnt_hi;
    logic       err;

    modport master (
        output ps2_ready, ps2_data, ps2_overflow,
        input  ps2_nextdata_n, key_code, key_ext, key_valid, cnt_lo, cnt_hi, err
    );

    modport slave (
        input  ps2_ready, ps2_data, ps2_overflow,
        output ps2_nextdata_n, key_code, key_ext, key_valid, cnt_lo, cnt_hi, err
    );
endinterface

// File: rtl/kbd_ctrl.sv
// Keyboard controller: drains PS/2 scan codes, decodes make/break/E0 sequences, tracks the
// held key and a BCD press count. Optional prefix timeout enabled by macro KBD_CTRL_TIMEOUT_EN.
module kbd_ctrl #(
    parameter int TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    kbd_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_byte;
    logic [7:0] w_byte_nxt;
    logic       r_brk;
    logic       w_brk_nxt;
    logic       r_ext;
    logic       w_ext_nxt;
    logic       r_nextdata_n;
    logic       w_nextdata_n_nxt;
    logic [7:0] r_key_code;
    logic [7:0] w_key_code_nxt;
    logic       r_key_ext;
    logic       w_key_ext_nxt;
    logic       r_key_valid;
    logic       w_key_valid_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_err;
    logic       w_err_nxt;

`ifdef KBD_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            if (hi == 4'd9) begin
                hi = 4'd0;
            end else begin
                hi = hi + 4'd1;
            end
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and decode logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_byte_nxt       = r_byte;
        w_brk_nxt        = r_brk;
        w_ext_nxt        = r_ext;
        w_nextdata_n_nxt = 1'b1;
        w_key_code_nxt   = r_key_code;
        w_key_ext_nxt    = r_key_ext;
        w_key_valid_nxt  = r_key_valid;
        w_cnt_nxt        = r_cnt;
        w_err_nxt        = r_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.ps2_overflow) begin
                    w_err_nxt = 1'b1;
                    w_brk_nxt = 1'b0;
                    w_ext_nxt = 1'b0;
                end else begin
                    w_err_nxt = r_err;
                end
                // Pop pulse is registered, so it is launched here and lands on the POP cycle.
                if (bus.ps2_ready) begin
                    w_byte_nxt       = bus.ps2_data;
                    w_nextdata_n_nxt = 1'b0;
                    w_state_nxt      = ST_POP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_POP: begin
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_nxt = ST_IDLE;
                if (r_byte == 8'hF0) begin
                    w_brk_nxt = 1'b1;
                end else if (r_byte == 8'hE0) begin
                    w_ext_nxt = 1'b1;
                end else if (r_brk) begin
                    if (r_key_valid && (r_byte == r_key_code) && (r_ext == r_key_ext)) begin
                        w_key_valid_nxt = 1'b0;
                    end else begin
                        w_key_valid_nxt = r_key_valid;
                    end
                    w_brk_nxt = 1'b0;
                    w_ext_nxt = 1'b0;
                end else begin
                    // A make equal to the held key is typematic repeat and is ignored.
                    if (!r_key_valid || ({r_ext, r_byte} != {r_key_ext, r_key_code})) begin
                        w_key_code_nxt  = r_byte;
                        w_key_ext_nxt   = r_ext;
                        w_key_valid_nxt = 1'b1;
                        w_cnt_nxt       = bcd_inc(r_cnt);
                    end else begin
                        w_key_valid_nxt = r_key_valid;
                    end
                    w_ext_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef KBD_CTRL_TIMEOUT_EN
        w_to_cnt_nxt = r_to_cnt;
        if ((r_state == ST_IDLE) && bus.ps2_ready) begin
            w_to_cnt_nxt = '0;
        end else if ((r_state == ST_IDLE) && (r_brk || r_ext)) begin
            if (r_to_cnt == TO_MAX) begin
                w_to_cnt_nxt = '0;
                w_brk_nxt    = 1'b0;
                w_ext_nxt    = 1'b0;
            end else begin
                w_to_cnt_nxt = r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
            end
        end else begin
            w_to_cnt_nxt = r_to_cnt;
        end
`endif
    end

    // Datapath, flag and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte       <= 8'h00;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            r_nextdata_n <= 1'b1;
            r_key_code   <= 8'h00;
            r_key_ext    <= 1'b0;
            r_key_valid  <= 1'b0;
            r_cnt        <= 8'h00;
            r_err        <= 1'b0;
        end else begin
            r_byte       <= w_byte_nxt;
            r_brk        <= w_brk_nxt;
            r_ext        <= w_ext_nxt;
            r_nextdata_n <= w_nextdata_n_nxt;
            r_key_code   <= w_key_code_nxt;
            r_key_ext    <= w_key_ext_nxt;
            r_key_valid  <= w_key_valid_nxt;
            r_cnt        <= w_cnt_nxt;
            r_err        <= w_err_nxt;
        end
    end

`ifdef KBD_CTRL_TIMEOUT_EN
    // Idle counter for dangling prefixes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    assign bus.ps2_nextdata_n = r_nextdata_n;
    assign bus.key_code       = r_key_code;
    assign bus.key_ext        = r_key_ext;
    assign bus.key_valid      = r_key_valid;
    assign bus.cnt_lo         = r_cnt[3:0];
    assign bus.cnt_hi         = r_cnt[7:4];
    assign bus.err            = r_err;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed self-checking bench for kbd_ctrl; models the keyboard FIFO as a byte array.
module tb_kbd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] mem [0:511];
    int   wp = 0;
    int   rp = 0;

    always #5 clk = ~clk;

    kbd_ctrl_if bus ();

    kbd_ctrl #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.ps2_ready = (wp != rp);
    assign bus.ps2_data  = mem[rp[8:0]];

    always @(posedge clk) begin
        if (!bus.ps2_nextdata_n && (rp != wp)) rp <= rp + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wp[8:0]] = b;
        wp = wp + 1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rp == wp) break;
        end
        n_checks++;
        if (rp != wp) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes left, expected 0", wp - rp);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ps2_overflow = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ps2_nextdata_n, bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo, bus.err} !== {1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got nd=%b code=%h ext=%b valid=%b cnt=%h%h err=%b, expected nd=1 code=00 ext=0 valid=0 cnt=00 err=0",
                     bus.ps2_nextdata_n, bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo, bus.err);
        end
    endtask

    task automatic test_make();
        int lows;
        lows = 0;
        push(8'h1C);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!bus.ps2_nextdata_n) lows++;
        end
        n_checks++;
        if (lows != 1) begin
            n_fail++;
            $display("FAIL pop_pulse_width: got %0d low cycles, expected 1", lows);
        end
        n_checks++;
        if ({bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo} !== {8'h1C, 1'b0, 1'b1, 4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL make_1c: got code=%h ext=%b valid=%b cnt=%h%h, expected code=1c ext=0 valid=1 cnt=01",
                     bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo);
        end
    endtask

    task automatic test_typematic();
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain();
        n_checks++;
        if ({bus.key_valid, bus.cnt_hi, bus.cnt_lo} !== {1'b1, 4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL typematic: got valid=%b cnt=%h%h, expected valid=1 cnt=01", bus.key_valid, bus.cnt_hi, bus.cnt_lo);
        end
        push(8'hF0); push(8'h1C);
        drain();
        n_checks++;
        if ({bus.key_valid, bus.cnt_hi, bus.cnt_lo} !== {1'b0, 4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL release_1c: got valid=%b cnt=%h%h, expected valid=0 cnt=01", bus.key_valid, bus.cnt_hi, bus.cnt_lo);
        end
    endtask

    task automatic test_ext();
        push(8'hE0); push(8'h75);
        drain();
        n_checks++;
        if ({bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo} !== {8'h75, 1'b1, 1'b1, 4'd0, 4'd2}) begin
            n_fail++;
            $display("FAIL ext_make: got code=%h ext=%b valid=%b cnt=%h%h, expected code=75 ext=1 valid=1 cnt=02",
                     bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo);
        end
        push(8'hF0); push(8'h75);
        drain();
        n_checks++;
        if (bus.key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_plain_release: got valid=%b, expected 1", bus.key_valid);
        end
        push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        n_checks++;
        if ({bus.key_valid, bus.cnt_hi, bus.cnt_lo} !== {1'b0, 4'd0, 4'd2}) begin
            n_fail++;
            $display("FAIL ext_release: got valid=%b cnt=%h%h, expected valid=0 cnt=02", bus.key_valid, bus.cnt_hi, bus.cnt_lo);
        end
    endtask

    task automatic test_bcd_wrap();
        logic [3:0] exp_hi;
        logic [3:0] exp_lo;
        test_reset();
        for (int k = 1; k <= 100; k++) begin
            push(((k % 2) == 1) ? 8'h1C : 8'h32);
            drain();
            exp_hi = 4'((k % 100) / 10);
            exp_lo = 4'((k % 100) % 10);
            n_checks++;
            if ({bus.cnt_hi, bus.cnt_lo} !== {exp_hi, exp_lo}) begin
                n_fail++;
                $display("FAIL bcd_count_%0d: got %h%h, expected %h%h", k, bus.cnt_hi, bus.cnt_lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_overflow();
        push(8'hF0);
        drain();
        bus.ps2_overflow = 1'b1;
        @(negedge clk);
        bus.ps2_overflow = 1'b0;
        push(8'h1C);
        drain();
        n_checks++;
        if ({bus.err, bus.key_code, bus.key_valid, bus.cnt_hi, bus.cnt_lo} !== {1'b1, 8'h1C, 1'b1, 4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL overflow_make: got err=%b code=%h valid=%b cnt=%h%h, expected err=1 code=1c valid=1 cnt=01",
                     bus.err, bus.key_code, bus.key_valid, bus.cnt_hi, bus.cnt_lo);
        end
        push(8'hF0);
        drain();
        bus.ps2_overflow = 1'b1;
        push(8'h1C);
        @(negedge clk);
        bus.ps2_overflow = 1'b0;
        drain();
        n_checks++;
        if ({bus.err, bus.key_valid, bus.cnt_hi, bus.cnt_lo} !== {1'b1, 1'b1, 4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL overflow_same_cycle: got err=%b valid=%b cnt=%h%h, expected err=1 valid=1 cnt=01",
                     bus.err, bus.key_valid, bus.cnt_hi, bus.cnt_lo);
        end
    endtask

    task automatic test_timeout();
        logic exp_valid;
`ifdef KBD_CTRL_TIMEOUT_EN
        exp_valid = 1'b1;
`else
        exp_valid = 1'b0;
`endif
        push(8'hF0);
        drain();
        repeat (20) @(negedge clk);
        push(8'h1C);
        drain();
        n_checks++;
        if ({bus.key_valid, bus.key_code, bus.cnt_hi, bus.cnt_lo} !== {exp_valid, 8'h1C, 4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL prefix_timeout: got valid=%b code=%h cnt=%h%h, expected valid=%b code=1c cnt=01",
                     bus.key_valid, bus.key_code, bus.cnt_hi, bus.cnt_lo, exp_valid);
        end
    endtask

    task automatic test_reset_mid_pop();
        push(8'h5A);
        @(negedge clk);
        n_checks++;
        if (bus.ps2_nextdata_n !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_before_reset: got nd=%b, expected 0", bus.ps2_nextdata_n);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.ps2_nextdata_n, bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo, bus.err} !== {1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_pop: got nd=%b code=%h ext=%b valid=%b cnt=%h%h err=%b, expected nd=1 code=00 ext=0 valid=0 cnt=00 err=0",
                     bus.ps2_nextdata_n, bus.key_code, bus.key_ext, bus.key_valid, bus.cnt_hi, bus.cnt_lo, bus.err);
        end
        @(negedge clk);
        rst = 1'b0;
        drain();
        n_checks++;
        if ({bus.key_code, bus.key_valid, bus.cnt_hi, bus.cnt_lo, bus.err} !== {8'h5A, 1'b1, 4'd0, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset_press: got code=%h valid=%b cnt=%h%h err=%b, expected code=5a valid=1 cnt=01 err=0",
                     bus.key_code, bus.key_valid, bus.cnt_hi, bus.cnt_lo, bus.err);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        test_reset();
        test_make();
        test_typematic();
        test_ext();
        test_bcd_wrap();
        test_overflow();
        test_timeout();
        test_reset_mid_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kbd_ctrl.md
# kbd_ctrl

Keyboard controller that sits between `ps2_keyboard` and the seven-segment/display logic. It drains scan-code bytes from the keyboard FIFO with the ready/`nextdata_n` handshake and decodes make, break and `E0`-extended sequences. It tracks the currently held key and keeps a BCD count (00–99) of distinct key presses for the `seg` block.

## Interface
Parameters:
- `TIMEOUT`, default 1000000: idle cycles after which a dangling `E0`/`F0` prefix is discarded. Used only with `KBD_CTRL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_ready`  in  1  keyboard FIFO non-empty.
- `ps2_data`  in  8  byte at FIFO head; valid while `ps2_ready`=1.
- `ps2_overflow`  in  1  keyboard FIFO overflow flag (level).
- `ps2_nextdata_n`  out  1  registered, active-low; one-cycle low pulse pops the FIFO head.
- `key_code`  out  8  scan code of the held key (without prefixes).
- `key_ext`  out  1  held key was `E0`-prefixed.
- `key_valid`  out  1  a key is currently held.
- `cnt_lo`  out  4  press count, BCD units digit.
- `cnt_hi`  out  4  press count, BCD tens digit.
- `err`  out  1  sticky overflow seen; cleared only by `rst`.

## Operation
- State machine: IDLE → POP → DECODE → IDLE.
  - IDLE: if `ps2_ready`=1, latch `ps2_data` into `byte_q` and go to POP; otherwise stay.
  - POP: `ps2_nextdata_n`=0 for exactly this cycle; go to DECODE.
  - DECODE: process `byte_q`; go to IDLE.
- Internal flags: `brk_pend` and `ext_pend`, both cleared by reset.
- Decode rules in DECODE:
  - `F0`: set `brk_pend`.
  - `E0`: set `ext_pend`.
  - Other byte with `brk_pend`=1: a release. If `key_valid` && `byte_q`==`key_code` && `ext_pend`==`key_ext`, clear `key_valid`; otherwise held-key state is unchanged. Clear both flags.
  - Other byte with `brk_pend`=0: a make. If `key_valid`=0, or the {`ext_pend`,`byte_q`} pair differs from {`key_ext`,`key_code`}, it is a new press: load `key_code`/`key_ext`, set `key_valid`, increment the count. A make matching the held key is typematic repeat: no state change, no increment. Clear `ext_pend`.
- Count is BCD: units 9→0 carries into tens; 99→00 wraps.
- Overflow: `ps2_overflow`=1 sampled in IDLE sets `err` and clears `brk_pend`/`ext_pend`. Bytes continue to be drained normally.
- The byte is never consumed outside the POP cycle. `ps2_ready` is ignored in POP and DECODE.

## Timing
- Reset values: `ps2_nextdata_n`=1, `key_code`=00, `key_ext`=0, `key_valid`=0, `cnt_hi`/`cnt_lo`=0/0, `err`=0, state IDLE, flags cleared.
- Per byte: 3 cycles from the IDLE cycle that sees `ps2_ready`=1 back to IDLE. Maximum throughput is 1 byte per 3 cycles.
- Outputs update on the clock edge leaving DECODE, i.e. 3 edges after the accepting IDLE cycle.
- Back-to-back bytes: `ps2_ready` is re-sampled in the IDLE cycle following DECODE, which is after the keyboard has advanced its read pointer.
- Reset mid-POP: `ps2_nextdata_n` returns to 1 asynchronously. The byte may or may not have been popped; the partial sequence is discarded.
- `ps2_overflow` and a ready byte in the same IDLE cycle: both take effect. The flags are cleared and the byte is latched.

## Configuration
- `KBD_CTRL_TIMEOUT_EN` defined:
  - A counter runs while in IDLE with `brk_pend`|`ext_pend` set, and resets whenever a byte is accepted.
  - When it reaches `TIMEOUT`-1, both flags clear on the next edge.
  - Held-key state and count are untouched.
- Not defined: no counter is built, and prefixes persist until the next byte.

## Test plan
- Reset, then push `1C` → `ps2_nextdata_n` low exactly 1 cycle; `key_code`=1C, `key_valid`=1, `key_ext`=0, cnt=01.
- Push `1C 1C 1C` (typematic) then `F0 1C` → cnt stays 01; `key_valid`=0 after `1C` following `F0`.
- Push `E0 75`, then `F0 75` → `key_ext`=1, cnt+1; the non-extended release leaves `key_valid`=1; then `E0 F0 75` → `key_valid`=0.
- 100 distinct alternating presses (`1C`,`32`,…) → cnt steps through 99 then wraps to 00; `cnt_hi` carries at each x9→(x+1)0.
- Assert `ps2_overflow` with `F0` pending, then push `1C` → `err`=1 (sticky), `1C` treated as a make press, cnt+1.
- With `KBD_CTRL_TIMEOUT_EN` and `TIMEOUT`=16: push `F0`, idle 20 cycles, push `1C` → treated as make (`key_valid`=1). Without the macro the same stimulus releases the key. Also assert `rst` during POP → all outputs at reset values immediately.
